// File: rtl/bitread_arbiter.sv
// bitread_arbiter: one stage of the daisy-chained read arbiter for the shared bit RAM.
// Latency: request sampled at E0, ISSUE in cycle 2 at the earliest, ACK in cycle 3+RAM_LATENCY.
// Backpressure: the request waits in PEND until the token (RE_PREV) is seen; once issued it cannot stall.
//
// Ports:
//   CLK, RST                     clock; asynchronous active-high reset
//   READARBITER_RE_PREV          token from the higher-priority stage (1 = bus free for us)
//   READARBITER_RE               core read request (level, 4-phase)
//   READARBITER_CORE_ReadADDR    core bit address, captured when the request is accepted
//   READARBITER_RAM_RE           single-cycle RAM read strobe
//   READARBITER_RAM_ReadADDR     shared tristate address bus, driven only while RAM_RE=1
//   READARBITER_RAM_ReadDATA     shared RAM read-data bit
//   READARBITER_CORE_ReadDATA    registered read result (held until the next completion)
//   READARBITER_ACK              one-cycle pulse, result valid
//   READARBITER_CARRY_OUT        token to the next lower-priority stage
module bitread_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int RAM_LATENCY = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              READARBITER_RE_PREV,
    input  logic              READARBITER_RE,
    input  logic [ADDR_W-1:0] READARBITER_CORE_ReadADDR,
    output logic              READARBITER_RAM_RE,
    output wire  [ADDR_W-1:0] READARBITER_RAM_ReadADDR,
    input  logic              READARBITER_RAM_ReadDATA,
    output logic              READARBITER_CORE_ReadDATA,
    output logic              READARBITER_ACK,
    output logic              READARBITER_CARRY_OUT
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PEND  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        HOLD  = 3'd4
    } state_t;

    // Counter reload: WAIT runs RAM_LATENCY cycles, the last one (cnt==0) samples the data line.
    localparam logic [2:0] CNT_LOAD = 3'(RAM_LATENCY - 1);

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        cnt;
    logic [ADDR_W-1:0] addr_reg;

    // State register and datapath
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state                     <= IDLE;
            cnt                       <= 3'd0;
            addr_reg                  <= '0;
            READARBITER_CORE_ReadDATA <= 1'b0;
            READARBITER_ACK           <= 1'b0;
        end else begin
            state           <= state_nxt;
            READARBITER_ACK <= 1'b0;
            case (state)
                IDLE: begin
                    if (READARBITER_RE) begin
                        addr_reg <= READARBITER_CORE_ReadADDR;
                    end
                end
                ISSUE: begin
                    cnt <= CNT_LOAD;
                end
                WAIT: begin
                    if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end else begin
                        READARBITER_CORE_ReadDATA <= READARBITER_RAM_ReadDATA;
                        READARBITER_ACK           <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and combinational outputs
    always_comb begin
        state_nxt             = state;
        READARBITER_RAM_RE    = 1'b0;
        READARBITER_CARRY_OUT = 1'b0;
        case (state)
            IDLE: begin
                // Token passes straight through unless we are about to claim it.
                READARBITER_CARRY_OUT = READARBITER_RE_PREV & ~READARBITER_RE;
                if (READARBITER_RE) begin
                    state_nxt = PEND;
                end
            end
            PEND: begin
                if (!READARBITER_RE) begin
                    state_nxt = IDLE;
                end else if (READARBITER_RE_PREV) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                READARBITER_RAM_RE = 1'b1;
                state_nxt          = WAIT;
            end
            WAIT: begin
                // Dropping RE here does not abort: the read is already in flight.
                if (cnt == 3'd0) begin
                    state_nxt = READARBITER_RE ? HOLD : IDLE;
                end
            end
            HOLD: begin
                // Done with the bus; release the token while the core finishes its handshake.
                READARBITER_CARRY_OUT = READARBITER_RE_PREV;
                if (!READARBITER_RE) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Shared address bus: only the stage in ISSUE drives it.
    assign READARBITER_RAM_ReadADDR = (state == ISSUE) ? addr_reg : {ADDR_W{1'bz}};

endmodule

// File: tb/tb_bitread_arbiter.sv
// Directed bench for bitread_arbiter: two chained LATENCY=1 stages sharing an address bus
// and a standalone LATENCY=3 stage. Pulled-up buses read back 16'hFFFF when nobody drives them.
module tb_bitread_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        prev_a, re_a, re_b, re_c, prev_c;
    logic [15:0] addr_a, addr_b, addr_c;
    logic        ram_dat, dat_c;
    logic        ram_re_a, ram_re_b, ram_re_c;
    logic        rd_a, rd_b, rd_c;
    logic        ack_a, ack_b, ack_c;
    logic        carry_a, carry_b, carry_c;
    tri1 [15:0]  bus_ab;
    tri1 [15:0]  bus_c;

    bitread_arbiter #(.ADDR_W(16), .RAM_LATENCY(1)) u_a (
        .CLK(clk), .RST(rst),
        .READARBITER_RE_PREV(prev_a), .READARBITER_RE(re_a),
        .READARBITER_CORE_ReadADDR(addr_a), .READARBITER_RAM_RE(ram_re_a),
        .READARBITER_RAM_ReadADDR(bus_ab), .READARBITER_RAM_ReadDATA(ram_dat),
        .READARBITER_CORE_ReadDATA(rd_a), .READARBITER_ACK(ack_a),
        .READARBITER_CARRY_OUT(carry_a)
    );

    bitread_arbiter #(.ADDR_W(16), .RAM_LATENCY(1)) u_b (
        .CLK(clk), .RST(rst),
        .READARBITER_RE_PREV(carry_a), .READARBITER_RE(re_b),
        .READARBITER_CORE_ReadADDR(addr_b), .READARBITER_RAM_RE(ram_re_b),
        .READARBITER_RAM_ReadADDR(bus_ab), .READARBITER_RAM_ReadDATA(ram_dat),
        .READARBITER_CORE_ReadDATA(rd_b), .READARBITER_ACK(ack_b),
        .READARBITER_CARRY_OUT(carry_b)
    );

    bitread_arbiter #(.ADDR_W(16), .RAM_LATENCY(3)) u_c (
        .CLK(clk), .RST(rst),
        .READARBITER_RE_PREV(prev_c), .READARBITER_RE(re_c),
        .READARBITER_CORE_ReadADDR(addr_c), .READARBITER_RAM_RE(ram_re_c),
        .READARBITER_RAM_ReadADDR(bus_c), .READARBITER_RAM_ReadDATA(dat_c),
        .READARBITER_CORE_ReadDATA(rd_c), .READARBITER_ACK(ack_c),
        .READARBITER_CARRY_OUT(carry_c)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge (start of the next cycle).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] mask;

    initial begin
        rst = 1'b1;
        prev_a = 1'b1; re_a = 1'b0; re_b = 1'b0; addr_a = '0; addr_b = '0;
        prev_c = 1'b1; re_c = 1'b0; addr_c = '0;
        ram_dat = 1'b0; dat_c = 1'b0;
        #2;
        chk("rst_ack", ack_a, 0);
        chk("rst_rdata", rd_a, 0);
        chk("rst_ram_re", ram_re_a, 0);
        chk("rst_bus", bus_ab, 16'hFFFF);
        chk("rst_carry_a", carry_a, 1);
        chk("rst_carry_b", carry_b, 1);
        chk("rst_ack_c", ack_c, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Test 1: token present, latency 1, addr 0x00A5, data 1
        re_a = 1'b1; addr_a = 16'h00A5; ram_dat = 1'b1;
        #1 chk("t1_carry_c0", carry_a, 0);
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk($sformatf("t1_ram_re_c%0d", c), ram_re_a, (c == 2));
            chk($sformatf("t1_bus_c%0d", c), bus_ab, (c == 2) ? 16'h00A5 : 16'hFFFF);
            chk($sformatf("t1_ack_c%0d", c), ack_a, (c == 4));
            if (c <= 3) chk($sformatf("t1_carry_c%0d", c), carry_a, 0);
            if (c == 4) begin
                chk("t1_rdata_c4", rd_a, 1);
                chk("t1_carry_hold", carry_a, 1);
            end
        end
        re_a = 1'b0; ram_dat = 1'b0;
        tick();

        // Test 2: token withheld for cycles 1..5, rises in cycle 6; data 0
        prev_a = 1'b0; re_a = 1'b1; addr_a = 16'h1234; ram_dat = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            tick();
            chk($sformatf("t2_ram_re_c%0d", c), ram_re_a, (c == 7));
            chk($sformatf("t2_bus_c%0d", c), bus_ab, (c == 7) ? 16'h1234 : 16'hFFFF);
            chk($sformatf("t2_ack_c%0d", c), ack_a, (c == 9));
            if (c <= 8) chk($sformatf("t2_carry_c%0d", c), carry_a, 0);
            if (c == 9) chk("t2_rdata_c9", rd_a, 0);
            if (c == 6) prev_a = 1'b1;
        end
        re_a = 1'b0;
        tick();

        // Test 3: latency 3; only the cycle-5 value may be captured
        for (int r = 0; r < 2; r++) begin
            mask = (r == 0) ? 8'b0010_0000 : 8'b0101_0000;
            re_c = 1'b1; addr_c = (r == 0) ? 16'h0C0C : 16'h0333; dat_c = mask[0];
            for (int c = 1; c <= 7; c++) begin
                tick();
                dat_c = mask[c];
                chk($sformatf("t3r%0d_ram_re_c%0d", r, c), ram_re_c, (c == 2));
                chk($sformatf("t3r%0d_bus_c%0d", r, c), bus_c,
                    (c == 2) ? ((r == 0) ? 16'h0C0C : 16'h0333) : 16'hFFFF);
                chk($sformatf("t3r%0d_ack_c%0d", r, c), ack_c, (c == 6));
                if (c == 6) chk($sformatf("t3r%0d_rdata", r), rd_c, (r == 0));
            end
            re_c = 1'b0; dat_c = 1'b0;
            tick();
        end

        // Test 4a: request withdrawn while pending
        prev_a = 1'b0; re_a = 1'b1; addr_a = 16'h0055;
        tick();
        chk("t4a_carry_pend", carry_a, 0);
        re_a = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk($sformatf("t4a_ram_re_c%0d", c), ram_re_a, 0);
            chk($sformatf("t4a_ack_c%0d", c), ack_a, 0);
            chk($sformatf("t4a_carry_c%0d", c), carry_a, 0);
        end
        prev_a = 1'b1;
        #1 chk("t4a_carry_follow", carry_a, 1);

        // Test 4b: request dropped during WAIT still completes
        re_a = 1'b1; addr_a = 16'h0077; ram_dat = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk($sformatf("t4b_ram_re_c%0d", c), ram_re_a, (c == 2));
            chk($sformatf("t4b_ack_c%0d", c), ack_a, (c == 4));
            if (c == 4) begin
                chk("t4b_rdata", rd_a, 1);
                chk("t4b_carry_idle", carry_a, 1);
            end
            if (c == 3) re_a = 1'b0;
        end

        // Test 5: reset in the middle of WAIT
        re_a = 1'b1; addr_a = 16'h00F0; ram_dat = 1'b1;
        tick();
        tick();
        chk("t5_issue", ram_re_a, 1);
        tick();
        rst = 1'b1; re_a = 1'b0;
        #1;
        chk("t5_ack", ack_a, 0);
        chk("t5_rdata", rd_a, 0);
        chk("t5_ram_re", ram_re_a, 0);
        chk("t5_bus", bus_ab, 16'hFFFF);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("t5_no_ack_%0d", c), ack_a, 0);
        end
        ram_dat = 1'b0;

        // Test 6: two chained stages requesting together
        prev_a = 1'b1;
        re_a = 1'b1; addr_a = 16'h0010;
        re_b = 1'b1; addr_b = 16'h0020;
        #1 chk("t6_carry_b_c0", carry_b, 0);
        for (int c = 1; c <= 8; c++) begin
            tick();
            ram_dat = (c == 3);
            chk($sformatf("t6_ram_re_a_c%0d", c), ram_re_a, (c == 2));
            chk($sformatf("t6_ram_re_b_c%0d", c), ram_re_b, (c == 5));
            chk($sformatf("t6_one_driver_c%0d", c), ram_re_a & ram_re_b, 0);
            chk($sformatf("t6_bus_c%0d", c), bus_ab,
                (c == 2) ? 16'h0010 : ((c == 5) ? 16'h0020 : 16'hFFFF));
            chk($sformatf("t6_ack_a_c%0d", c), ack_a, (c == 4));
            chk($sformatf("t6_ack_b_c%0d", c), ack_b, (c == 7));
            if (c == 4) begin
                chk("t6_rdata_a", rd_a, 1);
                chk("t6_carry_a_hold", carry_a, 1);
            end
            if (c == 7) chk("t6_rdata_b", rd_b, 0);
        end
        re_a = 1'b0; re_b = 1'b0; ram_dat = 1'b0;
        tick();
        tick();
        chk("t6_carry_b_end", carry_b, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
